// File: rtl/zero_run_classifier.sv
`default_nettype none
// ==========================================================================
// zero_run_classifier : streaming ZZZZ/ZZZX/NONE word classifier that
// folds consecutive all-zero words into ZRUN tokens.   rev 1.0
// ==========================================================================
module zero_run_classifier #(
  parameter int WIDTH   = 32,
  parameter int BYTE_W  = 8,
  parameter int RUN_EN  = 1,
  parameter int RUN_MAX = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WIDTH-1:0]  i_word,
  input  logic              i_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [1:0]        o_kind,
  output logic [BYTE_W+3:0] o_code,
  output logic [WIDTH-1:0]  o_word,
  output logic              o_match_s,
  output logic              o_type_matched,
  output logic              o_last,
  output logic              o_run_active
);

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_ZZZZ = 2'd1;
  localparam logic [1:0] K_ZZZX = 2'd2;
  localparam logic [1:0] K_ZRUN = 2'd3;
  localparam logic [3:0] C_PFX_ZZZX = 4'b1101;
  localparam logic [3:0] C_PFX_ZRUN = 4'b1110;
  localparam logic [BYTE_W-1:0] C_RUN_MAX = BYTE_W'(RUN_MAX);
  localparam logic [BYTE_W-1:0] C_ONE     = BYTE_W'(1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [BYTE_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;

  logic                r_valid;
  logic [1:0]          r_kind;
  logic [BYTE_W+3:0]   r_code;
  logic [WIDTH-1:0]    r_word;
  logic                r_last;

  logic                r_pend_v;
  logic [1:0]          r_pend_kind;
  logic [BYTE_W+3:0]   r_pend_code;
  logic [WIDTH-1:0]    r_pend_word;
  logic                r_pend_last;

  logic                w_load, w_acc, w_zero, w_high_zero;
  logic [1:0]          w_cls_kind;
  logic [BYTE_W+3:0]   w_cls_code;
  logic [WIDTH-1:0]    w_cls_word;
  logic [1:0]          w_run_kind;
  logic [BYTE_W+3:0]   w_run_code;

  logic                w_emit, w_e_last, w_pend_set;
  logic [1:0]          w_e_kind;
  logic [BYTE_W+3:0]   w_e_code;
  logic [WIDTH-1:0]    w_e_word;

  assign w_load      = ~r_valid | i_ready;
  // Gated by reset so the block never advertises ready while held in reset.
  assign o_ready     = i_rst_n & ~r_pend_v & w_load;
  assign w_acc       = i_valid & o_ready;
  assign w_zero      = (i_word == '0);
  assign w_high_zero = (i_word[WIDTH-1:BYTE_W] == '0);
  assign w_cnt_inc   = r_cnt + C_ONE;

  always_comb begin
    w_cls_kind = K_NONE;
    w_cls_code = '0;
    w_cls_word = i_word;
    if (w_zero) begin
      w_cls_kind = K_ZZZZ;
      w_cls_word = '0;
    end else if (w_high_zero) begin
      w_cls_kind = K_ZZZX;
      w_cls_code = {C_PFX_ZZZX, i_word[BYTE_W-1:0]};
      w_cls_word = '0;
    end
  end

  // A run interrupted after a single zero is reported as a plain ZZZZ.
  always_comb begin
    w_run_kind = K_ZRUN;
    w_run_code = {C_PFX_ZRUN, r_cnt};
    if (r_cnt == C_ONE) begin
      w_run_kind = K_ZZZZ;
      w_run_code = '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_emit      = 1'b0;
    w_e_kind    = K_NONE;
    w_e_code    = '0;
    w_e_word    = '0;
    w_e_last    = 1'b0;
    w_pend_set  = 1'b0;
    if (r_pend_v) begin
      if (w_load) begin
        w_emit   = 1'b1;
        w_e_kind = r_pend_kind;
        w_e_code = r_pend_code;
        w_e_word = r_pend_word;
        w_e_last = r_pend_last;
      end
    end else if (w_acc) begin
      case (r_state)
        S_IDLE: begin
          if (!w_zero) begin
            w_emit   = 1'b1;
            w_e_kind = w_cls_kind;
            w_e_code = w_cls_code;
            w_e_word = w_cls_word;
            w_e_last = i_last;
          end else if ((RUN_EN == 0) || i_last) begin
            w_emit   = 1'b1;
            w_e_kind = K_ZZZZ;
            w_e_last = i_last;
          end else begin
            w_cnt_nxt   = C_ONE;
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (w_zero) begin
            if ((w_cnt_inc == C_RUN_MAX) || i_last) begin
              w_emit      = 1'b1;
              w_e_kind    = K_ZRUN;
              w_e_code    = {C_PFX_ZRUN, w_cnt_inc};
              w_e_last    = i_last;
              w_cnt_nxt   = '0;
              w_state_nxt = S_IDLE;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            // Flush the run now; the breaking word waits in the pending slot.
            w_emit      = 1'b1;
            w_e_kind    = w_run_kind;
            w_e_code    = w_run_code;
            w_pend_set  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid     <= 1'b0;
      r_kind      <= K_NONE;
      r_code      <= '0;
      r_word      <= '0;
      r_last      <= 1'b0;
      r_pend_v    <= 1'b0;
      r_pend_kind <= K_NONE;
      r_pend_code <= '0;
      r_pend_word <= '0;
      r_pend_last <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= w_emit;
        r_kind  <= w_e_kind;
        r_code  <= w_e_code;
        r_word  <= w_e_word;
        r_last  <= w_e_last;
      end
      if (w_pend_set) begin
        r_pend_v    <= 1'b1;
        r_pend_kind <= w_cls_kind;
        r_pend_code <= w_cls_code;
        r_pend_word <= w_cls_word;
        r_pend_last <= i_last;
      end else if (r_pend_v && w_load) begin
        r_pend_v <= 1'b0;
      end
    end
  end

  assign o_valid        = r_valid;
  assign o_kind         = r_kind;
  assign o_code         = r_code;
  assign o_word         = r_word;
  assign o_last         = r_last;
  assign o_match_s      = (r_kind != K_NONE);
  assign o_type_matched = (r_kind == K_ZZZZ) | (r_kind == K_ZRUN);
  assign o_run_active   = (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_zero_run_classifier.sv
`default_nettype none
// Testbench for zero_run_classifier: three instances (default, RUN_MAX=4,
// RUN_EN=0) driven with directed vectors.
module tb_zero_run_classifier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        vld [3];
  logic [31:0] wrd [3];
  logic        lst [3];
  logic        irdy[3];
  logic        ordy[3];
  logic        ovld[3];
  logic [1:0]  kind[3];
  logic [11:0] code[3];
  logic [31:0] owrd[3];
  logic        ms  [3];
  logic        tm  [3];
  logic        olast[3];
  logic        ra  [3];

  int total = 0;
  int bad   = 0;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      zero_run_classifier #(
        .WIDTH(32), .BYTE_W(8),
        .RUN_EN((g == 2) ? 0 : 1),
        .RUN_MAX((g == 1) ? 4 : 255)
      ) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(vld[g]), .o_ready(ordy[g]),
        .i_word(wrd[g]), .i_last(lst[g]),
        .o_valid(ovld[g]), .i_ready(irdy[g]),
        .o_kind(kind[g]), .o_code(code[g]), .o_word(owrd[g]),
        .o_match_s(ms[g]), .o_type_matched(tm[g]),
        .o_last(olast[g]), .o_run_active(ra[g])
      );
    end
  endgenerate

  // {valid, kind, code, word, match_s, type_matched, last}
  function automatic logic [49:0] tok(input int d);
    return {ovld[d], kind[d], code[d], owrd[d], ms[d], tm[d], olast[d]};
  endfunction

  function automatic logic [49:0] mk(input logic v, input logic [1:0] k,
                                     input logic [11:0] c, input logic [31:0] w,
                                     input logic m, input logic t, input logic l);
    return {v, k, c, w, m, t, l};
  endfunction

  task automatic put(input int d, input logic [31:0] w, input logic l);
    vld[d] = 1'b1; wrd[d] = w; lst[d] = l;
    @(posedge clk); #1;
    vld[d] = 1'b0; wrd[d] = '0; lst[d] = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0; wrd[i] = '0; lst[i] = 1'b0; irdy[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({tok(0), ordy[0], ra[0]} !== 52'h0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0", {tok(0), ordy[0], ra[0]});
    end
    @(negedge clk) rst_n = 1'b1;
    idle();
    total++;
    if (ordy[0] !== 1'b1) begin
      bad++; $display("FAIL reset_ready: got %b want 1", ordy[0]);
    end
  endtask

  task automatic test_single();
    logic [49:0] e;
    put(0, 32'h0, 1'b1);
    e = mk(1, 2'd1, 12'h000, 32'h0, 1, 1, 1);
    total++;
    if (tok(0) !== e) begin bad++; $display("FAIL single_zzzz: got %h want %h", tok(0), e); end
    put(0, 32'h0000_00A5, 1'b1);
    e = mk(1, 2'd2, 12'hDA5, 32'h0, 1, 0, 1);
    total++;
    if (tok(0) !== e) begin bad++; $display("FAIL single_zzzx: got %h want %h", tok(0), e); end
    put(0, 32'h1234_5678, 1'b1);
    e = mk(1, 2'd0, 12'h000, 32'h1234_5678, 0, 0, 1);
    total++;
    if (tok(0) !== e) begin bad++; $display("FAIL single_none: got %h want %h", tok(0), e); end
    idle();
    total++;
    if (ovld[0] !== 1'b0) begin bad++; $display("FAIL single_drain: got %b want 0", ovld[0]); end
  endtask

  task automatic test_run_pending();
    logic [49:0] e;
    for (int i = 0; i < 5; i++) put(0, 32'h0, 1'b0);
    total++;
    if ({ovld[0], ra[0]} !== 2'b01) begin
      bad++; $display("FAIL run_held: got %b want 01", {ovld[0], ra[0]});
    end
    put(0, 32'h0000_0042, 1'b1);
    e = mk(1, 2'd3, 12'hE05, 32'h0, 1, 1, 0);
    total++;
    if (tok(0) !== e) begin bad++; $display("FAIL run_token: got %h want %h", tok(0), e); end
    total++;
    if ({ordy[0], ra[0]} !== 2'b00) begin
      bad++; $display("FAIL run_pend_stall: got %b want 00", {ordy[0], ra[0]});
    end
    idle();
    e = mk(1, 2'd2, 12'hD42, 32'h0, 1, 0, 1);
    total++;
    if ({tok(0), ordy[0]} !== {e, 1'b1}) begin
      bad++; $display("FAIL run_pend_token: got %h want %h", {tok(0), ordy[0]}, {e, 1'b1});
    end
    idle();
    total++;
    if (ovld[0] !== 1'b0) begin bad++; $display("FAIL run_drain: got %b want 0", ovld[0]); end
  endtask

  task automatic test_one_zero();
    logic [49:0] e;
    put(0, 32'h0, 1'b0);
    total++;
    if ({ovld[0], ra[0]} !== 2'b01) begin
      bad++; $display("FAIL one_zero_held: got %b want 01", {ovld[0], ra[0]});
    end
    put(0, 32'hDEAD_BEEF, 1'b0);
    e = mk(1, 2'd1, 12'h000, 32'h0, 1, 1, 0);
    total++;
    if (tok(0) !== e) begin bad++; $display("FAIL one_zero_zzzz: got %h want %h", tok(0), e); end
    idle();
    e = mk(1, 2'd0, 12'h000, 32'hDEAD_BEEF, 0, 0, 0);
    total++;
    if (tok(0) !== e) begin bad++; $display("FAIL one_zero_none: got %h want %h", tok(0), e); end
    idle();
  endtask

  task automatic test_run_max();
    logic [49:0] e;
    for (int i = 1; i <= 9; i++) begin
      put(1, 32'h0, (i == 9));
      total++;
      if (i == 4 || i == 8) begin
        e = mk(1, 2'd3, 12'hE04, 32'h0, 1, 1, 0);
        if (tok(1) !== e) begin bad++; $display("FAIL run_max_%0d: got %h want %h", i, tok(1), e); end
      end else if (i == 9) begin
        e = mk(1, 2'd1, 12'h000, 32'h0, 1, 1, 1);
        if (tok(1) !== e) begin bad++; $display("FAIL run_max_%0d: got %h want %h", i, tok(1), e); end
      end else begin
        if (ovld[1] !== 1'b0) begin bad++; $display("FAIL run_max_%0d: valid got %b want 0", i, ovld[1]); end
      end
    end
    idle();
  endtask

  task automatic test_no_run();
    logic [50:0] e;
    for (int i = 0; i < 3; i++) begin
      put(2, 32'h0, 1'b0);
      e = {mk(1, 2'd1, 12'h000, 32'h0, 1, 1, 0), 1'b0};
      total++;
      if ({tok(2), ra[2]} !== e) begin
        bad++; $display("FAIL no_run_%0d: got %h want %h", i, {tok(2), ra[2]}, e);
      end
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [49:0] e;
    irdy[0] = 1'b0;
    put(0, 32'h0000_0077, 1'b0);
    e = mk(1, 2'd2, 12'hD77, 32'h0, 1, 0, 0);
    total++;
    if (tok(0) !== e) begin bad++; $display("FAIL bp_first: got %h want %h", tok(0), e); end
    vld[0] = 1'b1; wrd[0] = 32'h55AA_55AA; lst[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle();
      total++;
      if ({tok(0), ordy[0]} !== {e, 1'b0}) begin
        bad++; $display("FAIL bp_hold_%0d: got %h want %h", i, {tok(0), ordy[0]}, {e, 1'b0});
      end
    end
    irdy[0] = 1'b1;
    idle();
    vld[0] = 1'b0; wrd[0] = '0; lst[0] = 1'b0;
    e = mk(1, 2'd0, 12'h000, 32'h55AA_55AA, 0, 0, 1);
    total++;
    if (tok(0) !== e) begin bad++; $display("FAIL bp_release: got %h want %h", tok(0), e); end
    idle();
    total++;
    if (ovld[0] !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", ovld[0]); end
  endtask

  task automatic test_reset_mid_run();
    logic [49:0] e;
    for (int i = 0; i < 3; i++) put(0, 32'h0, 1'b0);
    total++;
    if (ra[0] !== 1'b1) begin bad++; $display("FAIL rst_run_active: got %b want 1", ra[0]); end
    #1 rst_n = 1'b0;
    #2;
    total++;
    if ({tok(0), ordy[0], ra[0]} !== 52'h0) begin
      bad++; $display("FAIL rst_mid_outputs: got %h want 0", {tok(0), ordy[0], ra[0]});
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) idle();
    total++;
    if ({ovld[0], ra[0]} !== 2'b00) begin
      bad++; $display("FAIL rst_no_stale: got %b want 00", {ovld[0], ra[0]});
    end
    put(0, 32'h0000_0011, 1'b1);
    e = mk(1, 2'd2, 12'hD11, 32'h0, 1, 0, 1);
    total++;
    if (tok(0) !== e) begin bad++; $display("FAIL rst_after_word: got %h want %h", tok(0), e); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_run_pending();
    test_one_zero();
    test_run_max();
    test_no_run();
    test_backpressure();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
